// File: rtl/is_pkg_uart_controller.sv
// Shared types and helpers for the UART controller command layer.
// Holds the sequencer state enum, ASCII constants and hex conversion.
package is_pkg_uart_controller;

    localparam int DATA_RX_W      = 48;
    localparam int RX_PAYLOAD_MAX = DATA_RX_W / 8;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_E  = 8'h45;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_W  = 8'h57;

    typedef enum logic [3:0] {
        IDLE,
        RDT,
        RCR,
        RLF,
        TRES,
        TMEM,
        TDT,
        TCR,
        TLF
    } state_f;

    typedef struct packed {
        logic       ok;
        logic [3:0] val;
    } hexnib_t;

    // ASCII hex digit (either case) to nibble, with a validity flag.
    function automatic hexnib_t hex2nib(input logic [7:0] c);
        hexnib_t r;
        r.ok  = 1'b1;
        r.val = c[3:0];
        if (c >= 8'h30 && c <= 8'h39) begin
            r.val = c[3:0];
        end else if ((c >= 8'h41 && c <= 8'h46) ||
                     (c >= 8'h61 && c <= 8'h66)) begin
            r.val = c[3:0] + 4'd9;
        end else begin
            r.ok = 1'b0;
        end
        return r;
    endfunction

    // Nibble to upper-case ASCII hex digit.
    function automatic logic [7:0] nib2hex(input logic [3:0] n);
        logic [7:0] r;
        if (n < 4'd10) r = {4'h3, n};
        else           r = 8'h37 + {4'h0, n};
        return r;
    endfunction

endpackage

// File: rtl/uart_cmd_sequencer.sv
// Frame-level command sequencer: assembles CR/LF frames from UART RX,
// decodes R/W commands, drives the register memory and the TX response.
// Ports: clk/rst, rx_data/rx_valid/rx_perr (byte in), tx_data/tx_valid/
// tx_ready (byte out), mem_addr/mem_re/mem_rdata/mem_we/mem_wdata,
// cmd_done (response finished), err_cnt (saturating error count).
module uart_cmd_sequencer
    import is_pkg_uart_controller::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_perr,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cmd_done,
    output logic [7:0]        err_cnt
);

    state_f                 state_q, state_d;
    logic [DATA_RX_W-1:0]   pl_q, pl_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   perr_q, perr_d;
    logic                   rd_cmd_q, rd_cmd_d;
    logic                   ph_q, ph_d;
    logic [7:0]             rd_q, rd_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0]      tx_data_q, tx_data_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic                   mem_re_q, mem_re_d;
    logic                   mem_we_q, mem_we_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic                   cmd_done_q, cmd_done_d;
    logic [7:0]             err_cnt_q, err_cnt_d;
    logic                   err_inc;

    logic [7:0] op;
    hexnib_t    n1, n2, n3, n4;
    logic       is_r, is_w, rd_ok, wr_ok, dec_err;
    logic       tx_fire;

    assign op = pl_q[7:0];
    assign n1 = hex2nib(pl_q[15:8]);
    assign n2 = hex2nib(pl_q[23:16]);
    assign n3 = hex2nib(pl_q[31:24]);
    assign n4 = hex2nib(pl_q[39:32]);

    // Clearing bit 5 folds lower-case opcodes onto upper-case.
    assign is_r  = (op & 8'hDF) == ASCII_R;
    assign is_w  = (op & 8'hDF) == ASCII_W;
    assign rd_ok = is_r && cnt_q == 3'd3 && n1.ok && n2.ok;
    assign wr_ok = is_w && cnt_q == 3'd5 && n1.ok && n2.ok &&
                   n3.ok && n4.ok;
    // An empty payload fails both length checks.
    assign dec_err = ovf_q || perr_q || !(rd_ok || wr_ok);

    assign tx_fire = tx_valid_q && tx_ready;

    always_comb begin
        state_d     = state_q;
        pl_d        = pl_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        perr_d      = perr_q;
        rd_cmd_d    = rd_cmd_q;
        ph_d        = ph_q;
        rd_d        = rd_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        mem_addr_d  = mem_addr_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        cmd_done_d  = 1'b0;
        err_inc     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == ASCII_CR) begin
                        perr_d  = perr_q | rx_perr;
                        state_d = RCR;
                    end else if (rx_data != ASCII_LF) begin
                        pl_d[7:0] = rx_data;
                        cnt_d     = 3'd1;
                        perr_d    = perr_q | rx_perr;
                        state_d   = RDT;
                    end
                end
            end
            RDT: begin
                if (rx_valid) begin
                    perr_d = perr_q | rx_perr;
                    if (rx_data == ASCII_CR) begin
                        state_d = RCR;
                    end else if (cnt_q == 3'(RX_PAYLOAD_MAX)) begin
                        ovf_d = 1'b1;
                    end else begin
                        pl_d[{cnt_q, 3'b000} +: 8] = rx_data;
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            RCR: begin
                if (rx_valid) begin
                    if (rx_data == ASCII_LF) begin
                        perr_d  = perr_q | rx_perr;
                        state_d = RLF;
                        // Write strobe must be high while in RLF, so it
                        // is registered on the LF edge itself.
                        if (!dec_err && wr_ok && !rx_perr) begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = {n1.val, n2.val};
                            mem_wdata_d = {n3.val, n4.val};
                        end
                    end else begin
                        err_inc = 1'b1;
                        pl_d    = '0;
                        cnt_d   = 3'd0;
                        ovf_d   = 1'b0;
                        perr_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            RLF: begin
                err_inc    = dec_err;
                rd_cmd_d   = rd_ok && !dec_err;
                tx_valid_d = 1'b1;
                tx_data_d  = dec_err ? ASCII_E : ASCII_K;
                state_d    = TRES;
            end
            TRES: begin
                if (tx_fire) begin
                    if (rd_cmd_q) begin
                        tx_valid_d = 1'b0;
                        mem_re_d   = 1'b1;
                        mem_addr_d = {n1.val, n2.val};
                        ph_d       = 1'b0;
                        state_d    = TMEM;
                    end else begin
                        tx_data_d = ASCII_CR;
                        state_d   = TCR;
                    end
                end
            end
            TMEM: begin
                if (!ph_q) begin
                    ph_d = 1'b1;
                end else begin
                    rd_d       = mem_rdata;
                    tx_valid_d = 1'b1;
                    tx_data_d  = nib2hex(mem_rdata[7:4]);
                    ph_d       = 1'b0;
                    state_d    = TDT;
                end
            end
            TDT: begin
                if (tx_fire) begin
                    if (!ph_q) begin
                        tx_data_d = nib2hex(rd_q[3:0]);
                        ph_d      = 1'b1;
                    end else begin
                        tx_data_d = ASCII_CR;
                        ph_d      = 1'b0;
                        state_d   = TCR;
                    end
                end
            end
            TCR: begin
                if (tx_fire) begin
                    tx_data_d = ASCII_LF;
                    state_d   = TLF;
                end
            end
            TLF: begin
                if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    cmd_done_d = 1'b1;
                    pl_d       = '0;
                    cnt_d      = 3'd0;
                    ovf_d      = 1'b0;
                    perr_d     = 1'b0;
                    rd_cmd_d   = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        err_cnt_d = err_cnt_q;
        if (err_inc && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pl_q        <= '0;
            cnt_q       <= 3'd0;
            ovf_q       <= 1'b0;
            perr_q      <= 1'b0;
            rd_cmd_q    <= 1'b0;
            ph_q        <= 1'b0;
            rd_q        <= 8'h00;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            cmd_done_q  <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            pl_q        <= pl_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            perr_q      <= perr_d;
            rd_cmd_q    <= rd_cmd_d;
            ph_q        <= ph_d;
            rd_q        <= rd_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            cmd_done_q  <= cmd_done_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign cmd_done  = cmd_done_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Testbench for uart_cmd_sequencer: directed frames plus random frames
// compared against a frame-level reference model of the command protocol.
module tb_uart_cmd_sequencer;

    typedef logic [7:0] bq_t[$];

    logic       clk, rst;
    logic [7:0] rx_data;
    logic       rx_valid, rx_perr;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] mem_addr, mem_rdata, mem_wdata;
    logic       mem_re, mem_we, cmd_done;
    logic [7:0] err_cnt;

    int errs = 0;
    int n_checks = 0;
    int rdy_mode = 1;
    int err_model = 0;
    int done_cnt = 0;

    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  txq [$];
    logic [15:0] weq [$];
    logic [7:0]  req [$];

    bit         stall_prev = 0;
    logic [7:0] stall_data = 8'h00;

    string hexs = "0123456789ABCDEF";

    uart_cmd_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_perr   (rx_perr),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .cmd_done  (cmd_done),
        .err_cnt   (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Register memory: one-cycle read latency.
    initial begin
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            if (mem_re) mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       tx_ready = 1'b0;
                2:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b1;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Monitor: records handshakes/strobes, checks TX hold while stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 0;
            end else begin
                if (stall_prev)
                    chk("tx_hold", {23'b0, tx_valid, tx_data},
                        {24'h1, stall_data});
                stall_prev = tx_valid && !tx_ready;
                stall_data = tx_data;
                if (tx_valid && tx_ready) txq.push_back(tx_data);
                if (mem_we) weq.push_back({mem_addr, mem_wdata});
                if (mem_re) req.push_back(mem_addr);
                if (cmd_done) done_cnt++;
            end
        end
    end

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic int hval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return -1;
    endfunction

    function automatic logic [7:0] hexch(input int v, input bit lower);
        logic [7:0] c;
        c = hexs[v];
        if (lower && v >= 10) c = c + 8'h20;
        return c;
    endfunction

    // Frame-level reference: what the sequencer should answer.
    function automatic void model(input bq_t fr, input int perr_idx,
                                  output bq_t exp, output bit resp,
                                  output bit we, output logic [7:0] wa,
                                  output logic [7:0] wd, output bit re,
                                  output logic [7:0] ra);
        bq_t pl;
        int i = 0;
        bit bad;
        logic [7:0] op;
        logic [7:0] v;
        exp = {};
        resp = 0; we = 0; re = 0; wa = 0; wd = 0; ra = 0;
        while (i < fr.size() && fr[i] == 8'h0A) i++;
        while (i < fr.size() && fr[i] != 8'h0D) begin
            pl.push_back(fr[i]);
            i++;
        end
        i++;
        if (i >= fr.size() || fr[i] != 8'h0A) begin
            if (err_model < 255) err_model++;
            return;
        end
        resp = 1;
        bad = (perr_idx >= 0) || pl.size() == 0 || pl.size() > 6;
        op = 8'h00;
        if (!bad) begin
            op = pl[0];
            if (op >= "a" && op <= "z") op = op - 8'h20;
            if (op == "R" && pl.size() != 3) bad = 1;
            else if (op == "W" && pl.size() != 5) bad = 1;
            else if (op != "R" && op != "W") bad = 1;
            if (!bad)
                for (int k = 1; k < pl.size(); k++)
                    if (hval(pl[k]) < 0) bad = 1;
        end
        if (bad) begin
            if (err_model < 255) err_model++;
            exp = '{8'h45, 8'h0D, 8'h0A};
        end else if (op == "R") begin
            ra = 8'(hval(pl[1]) * 16 + hval(pl[2]));
            re = 1;
            v = ref_mem[ra];
            exp = '{8'h4B, hexch(int'(v[7:4]), 0), hexch(int'(v[3:0]), 0),
                    8'h0D, 8'h0A};
        end else begin
            wa = 8'(hval(pl[1]) * 16 + hval(pl[2]));
            wd = 8'(hval(pl[3]) * 16 + hval(pl[4]));
            we = 1;
            ref_mem[wa] = wd;
            exp = '{8'h4B, 8'h0D, 8'h0A};
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit pe);
        rx_data  = b;
        rx_perr  = pe;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_perr  = 1'b0;
    endtask

    task automatic do_frame(input bq_t fr, input int perr_idx,
                            input bit stall);
        bq_t exp;
        bit resp, we, re;
        logic [7:0] wa, wd, ra;
        int t;
        model(fr, perr_idx, exp, resp, we, wa, wd, re, ra);
        txq.delete();
        weq.delete();
        req.delete();
        done_cnt = 0;
        foreach (fr[i]) send_byte(fr[i], i == perr_idx);
        if (resp) begin
            chk("we_lf1", {31'b0, mem_we}, {31'b0, we});
            if (we) begin
                chk("we_addr_lf1", {24'b0, mem_addr}, {24'b0, wa});
                chk("we_data_lf1", {24'b0, mem_wdata}, {24'b0, wd});
            end
            @(posedge clk);
            #1;
            chk("status_lf2", {23'b0, tx_valid, tx_data},
                {23'b0, 1'b1, exp[0]});
            if (stall) begin
                send_byte(8'h5A, 1'b0);
                send_byte(8'h0D, 1'b0);
                send_byte(8'h0A, 1'b0);
                repeat (10) @(posedge clk);
                #1;
                chk("stall_data", {23'b0, tx_valid, tx_data},
                    {23'b0, 1'b1, 8'h4B});
                chk("stall_err", {24'b0, err_cnt}, err_model);
                rdy_mode = 1;
            end
            t = 0;
            while (done_cnt == 0 && t < 400) begin
                @(posedge clk);
                #1;
                t++;
            end
            repeat (3) @(posedge clk);
            #1;
        end else begin
            repeat (6) @(posedge clk);
            #1;
        end
        chk("tx_len", txq.size(), exp.size());
        for (int k = 0; k < exp.size() && k < txq.size(); k++)
            chk("tx_byte", {24'b0, txq[k]}, {24'b0, exp[k]});
        chk("done_cnt", done_cnt, resp ? 1 : 0);
        chk("we_cnt", weq.size(), we ? 1 : 0);
        if (we && weq.size() > 0)
            chk("we_pair", {16'b0, weq[0]}, {16'b0, wa, wd});
        chk("re_cnt", req.size(), re ? 1 : 0);
        if (re && req.size() > 0)
            chk("re_addr", {24'b0, req[0]}, {24'b0, ra});
        chk("err_cnt", {24'b0, err_cnt}, err_model);
    endtask

    initial begin
        bq_t fr;
        int kind, pidx, t;
        bit lo;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        rx_perr = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[8'h1F] = 8'hA5;
        ref_mem[8'h1F] = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {23'b0, tx_valid, tx_data}, 32'h0);
        chk("rst_mem", {14'b0, mem_re, mem_we, mem_addr, mem_wdata}, 32'h0);
        chk("rst_misc", {23'b0, cmd_done, err_cnt}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_frame(s2q("R1F\r\n"), -1, 0);
        do_frame(s2q("w2a3c\r\n"), -1, 0);
        do_frame(s2q("RG0\r\n"), -1, 0);
        do_frame(s2q("W123456\r\n"), -1, 0);
        do_frame(s2q("\r\n"), -1, 0);
        chk("err_three", {24'b0, err_cnt}, 32'd3);
        do_frame(s2q("R10\rX"), -1, 0);
        chk("err_drop", {24'b0, err_cnt}, 32'd4);
        do_frame(s2q("R10\r\n"), -1, 0);
        rdy_mode = 0;
        do_frame(s2q("R1F\r\n"), -1, 1);

        for (int n = 0; n < 40; n++) begin
            rdy_mode = (n % 2 == 0) ? 2 : 1;
            kind = $urandom_range(0, 5);
            lo = 1'($urandom_range(0, 1));
            fr = {};
            case (kind)
                0, 2:    fr.push_back(lo ? 8'h72 : 8'h52);
                4:       fr.push_back(8'h58);
                default: fr.push_back(lo ? 8'h77 : 8'h57);
            endcase
            for (int k = 0; k < (kind == 1 ? 4 : kind == 3 ? 6 : 2); k++)
                fr.push_back(hexch($urandom_range(0, 15), 1'($urandom_range(0, 1))));
            if (kind == 2) fr[1] = 8'h47;
            fr.push_back(8'h0D);
            fr.push_back(8'h0A);
            pidx = ($urandom_range(0, 7) == 0) ? 1 : -1;
            do_frame(fr, pidx, 0);
        end
        rdy_mode = 1;

        for (int n = 0; n < 256; n++) do_frame(s2q("\rX"), -1, 0);
        chk("err_sat", {24'b0, err_cnt}, 32'd255);

        txq.delete();
        send_byte(8'h52, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h0D, 1'b0);
        send_byte(8'h0A, 1'b0);
        t = 0;
        while (txq.size() < 2 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("tdt_reach", {31'b0, txq.size() >= 2}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_tx", {23'b0, tx_valid, tx_data}, 32'h0);
        chk("arst_mem", {14'b0, mem_re, mem_we, mem_addr, mem_wdata}, 32'h0);
        chk("arst_misc", {23'b0, cmd_done, err_cnt}, 32'h0);
        err_model = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_frame(s2q("R00\r\n"), -1, 0);

        $display("Result: errors=%0d of %0d checks", errs, n_checks);
        $finish;
    end

endmodule
